// File: rtl/qdma_stm_h2c_hdr_strip_if.sv
// AXI-Stream bundle used on both sides of the H2C header stripper.
// tuser marks a header beat on the input side; the output side always drives it low.
interface qdma_stm_h2c_hdr_strip_if #(
    parameter int DATA_W = 512,
    parameter int DEST_W = 16
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic [DEST_W-1:0] tdest;
    logic              tuser;
    logic              tlast;
    logic              tready;

    modport master (output tdata, tvalid, tdest, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tdest, tuser, tlast, output tready);
endinterface

// File: rtl/qdma_stm_h2c_hdr_strip.sv
// Strips the H2C stub header beat, checks packet framing, forwards payload with tdest,
// and queues one status record per packet. Header layout: qid at tdata[QID_BITS-1:0], tmh at tdata[63:32].
//
// state | meaning
// HDR   | expecting a header beat (reset state)
// PLD   | header seen, forwarding payload until tlast
// DROP  | packet started without a header, discarding until tlast
module qdma_stm_h2c_hdr_strip #(
    parameter int MAX_DATA_WIDTH = 512,
    parameter int TDEST_BITS     = 16,
    parameter int QID_BITS       = 11,
    parameter int TMH_BITS       = 32,
    parameter int CNT_BITS       = 16,
    parameter int STAT_DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    qdma_stm_h2c_hdr_strip_if.slave  in_axis,
    qdma_stm_h2c_hdr_strip_if.master out_axis,
    output logic                   stat_vld,
    input  logic                   stat_rdy,
    output logic [QID_BITS-1:0]    stat_qid,
    output logic [TMH_BITS-1:0]    stat_tmh,
    output logic [CNT_BITS-1:0]    stat_beats,
    output logic [3:0]             stat_err
);
    localparam int TMH_LSB = 32;
    localparam int AW      = $clog2(STAT_DEPTH);
    localparam int CW      = AW + 1;

    typedef enum logic [1:0] {S_HDR, S_PLD, S_DROP} state_t;

    state_t state, state_nxt;

    logic                      acc, fwd, push, pop, stat_full, hdr_mis;
    logic [QID_BITS-1:0]       qid_r, qid_nxt, hdr_qid, p_qid;
    logic [TMH_BITS-1:0]       tmh_r, tmh_nxt, hdr_tmh, p_tmh;
    logic [CNT_BITS-1:0]       cnt_r, cnt_nxt, cnt_inc, p_beats;
    logic [3:0]                err_r, err_nxt, p_err;

    logic                      out_vld;
    logic [MAX_DATA_WIDTH-1:0] out_data;
    logic [TDEST_BITS-1:0]     out_dest;
    logic                      out_last;

    logic [QID_BITS-1:0]       fq_qid   [STAT_DEPTH];
    logic [TMH_BITS-1:0]       fq_tmh   [STAT_DEPTH];
    logic [CNT_BITS-1:0]       fq_beats [STAT_DEPTH];
    logic [3:0]                fq_err   [STAT_DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             fcnt;

    assign hdr_qid   = in_axis.tdata[QID_BITS-1:0];
    assign hdr_tmh   = in_axis.tdata[TMH_LSB +: TMH_BITS];
    assign hdr_mis   = (in_axis.tdest[5:0] != hdr_qid[5:0]);
    assign cnt_inc   = (&cnt_r) ? cnt_r : cnt_r + CNT_BITS'(1);
    assign stat_full = (fcnt == CW'(STAT_DEPTH));

    // Holding off a full FIFO only on tlast beats means a push never meets a full queue.
    assign in_axis.tready = (!out_vld || out_axis.tready) && !(stat_full && in_axis.tlast);
    assign acc            = in_axis.tvalid && in_axis.tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_HDR;
            qid_r <= '0;
            tmh_r <= '0;
            cnt_r <= '0;
            err_r <= '0;
        end else begin
            state <= state_nxt;
            qid_r <= qid_nxt;
            tmh_r <= tmh_nxt;
            cnt_r <= cnt_nxt;
            err_r <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        qid_nxt   = qid_r;
        tmh_nxt   = tmh_r;
        cnt_nxt   = cnt_r;
        err_nxt   = err_r;
        fwd       = 1'b0;
        push      = 1'b0;
        p_qid     = qid_r;
        p_tmh     = tmh_r;
        p_beats   = cnt_r;
        p_err     = err_r;
        if (acc) begin
            case (state)
                S_HDR: begin
                    if (in_axis.tuser) begin
                        if (in_axis.tlast) begin
                            push    = 1'b1;
                            p_qid   = hdr_qid;
                            p_tmh   = hdr_tmh;
                            p_beats = '0;
                            p_err   = 4'b1000;
                        end else begin
                            qid_nxt   = hdr_qid;
                            tmh_nxt   = hdr_tmh;
                            cnt_nxt   = '0;
                            err_nxt   = {2'b00, hdr_mis, 1'b0};
                            state_nxt = S_PLD;
                        end
                    end else begin
                        qid_nxt = '0;
                        tmh_nxt = '0;
                        cnt_nxt = '0;
                        err_nxt = 4'b0001;
                        p_qid   = '0;
                        p_tmh   = '0;
                        p_beats = '0;
                        p_err   = 4'b0001;
                        if (in_axis.tlast) push = 1'b1;
                        else               state_nxt = S_DROP;
                    end
                end
                S_PLD: begin
                    if (!in_axis.tuser) begin
                        fwd     = 1'b1;
                        cnt_nxt = cnt_inc;
                        p_beats = cnt_inc;
                    end else begin
                        err_nxt = err_r | 4'b0100;
                        p_err   = err_r | 4'b0100;
                    end
                    if (in_axis.tlast) begin
                        push      = 1'b1;
                        state_nxt = S_HDR;
                    end
                end
                S_DROP: begin
                    if (in_axis.tlast) begin
                        push      = 1'b1;
                        state_nxt = S_HDR;
                    end
                end
                default: state_nxt = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_dest <= '0;
            out_last <= 1'b0;
        end else if (!out_vld || out_axis.tready) begin
            out_vld <= fwd;
            if (fwd) begin
                out_data <= in_axis.tdata;
                out_dest <= TDEST_BITS'(qid_r[5:0]);
                out_last <= in_axis.tlast;
            end
        end
    end

    assign out_axis.tvalid = out_vld;
    assign out_axis.tdata  = out_data;
    assign out_axis.tdest  = out_dest;
    assign out_axis.tlast  = out_last;
    assign out_axis.tuser  = 1'b0;

    assign pop = stat_vld && stat_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
            for (int i = 0; i < STAT_DEPTH; i++) begin
                fq_qid[i]   <= '0;
                fq_tmh[i]   <= '0;
                fq_beats[i] <= '0;
                fq_err[i]   <= '0;
            end
        end else begin
            if (push) begin
                fq_qid[wr_ptr]   <= p_qid;
                fq_tmh[wr_ptr]   <= p_tmh;
                fq_beats[wr_ptr] <= p_beats;
                fq_err[wr_ptr]   <= p_err;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fcnt <= fcnt + CW'(1);
            else if (!push && pop) fcnt <= fcnt - CW'(1);
        end
    end

    assign stat_vld   = (fcnt != '0);
    assign stat_qid   = fq_qid[rd_ptr];
    assign stat_tmh   = fq_tmh[rd_ptr];
    assign stat_beats = fq_beats[rd_ptr];
    assign stat_err   = fq_err[rd_ptr];
endmodule

// File: tb/tb_qdma_stm_h2c_hdr_strip.sv
// Directed bench for the H2C header stripper; expected beats and status records
// are queued at stimulus time and checked by an independent monitor.
module tb_qdma_stm_h2c_hdr_strip;
    localparam int DW = 512, DESTW = 16, QW = 11, TW = 32, CW = 16;

    typedef struct {
        logic [DW-1:0]    data;
        logic [DESTW-1:0] dest;
        logic             last;
    } ob_t;

    typedef struct {
        logic [QW-1:0] qid;
        logic [TW-1:0] tmh;
        logic [CW-1:0] beats;
        logic [3:0]    err;
    } st_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qdma_stm_h2c_hdr_strip_if #(.DATA_W(DW), .DEST_W(DESTW)) in_if ();
    qdma_stm_h2c_hdr_strip_if #(.DATA_W(DW), .DEST_W(DESTW)) out_if ();

    logic          stat_vld, stat_rdy;
    logic [QW-1:0] stat_qid;
    logic [TW-1:0] stat_tmh;
    logic [CW-1:0] stat_beats;
    logic [3:0]    stat_err;

    qdma_stm_h2c_hdr_strip #(
        .MAX_DATA_WIDTH(DW), .TDEST_BITS(DESTW), .QID_BITS(QW),
        .TMH_BITS(TW), .CNT_BITS(CW), .STAT_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .in_axis(in_if), .out_axis(out_if),
        .stat_vld(stat_vld), .stat_rdy(stat_rdy), .stat_qid(stat_qid),
        .stat_tmh(stat_tmh), .stat_beats(stat_beats), .stat_err(stat_err)
    );

    int  n_chk  = 0;
    int  n_pass = 0;
    ob_t exp_out[$];
    st_t exp_st[$];
    logic tog_en = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] hdr(input logic [QW-1:0] qid, input logic [TW-1:0] tmh);
        logic [DW-1:0] d;
        d            = '0;
        d[QW-1:0]    = qid;
        d[63:32]     = tmh;
        d[511:480]   = 32'hFEED_0000;
        return d;
    endfunction

    function automatic logic [DW-1:0] pld(input int k);
        logic [31:0] w;
        w = 32'hA5A5_0000 + 32'(k);
        return {16{w}};
    endfunction

    // output ready: held high, or toggled every cycle when tog_en
    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(negedge clk);
            if (tog_en) out_if.tready = ~out_if.tready;
            else        out_if.tready = 1'b1;
        end
    end

    // monitor: samples between the negedge drive and the next posedge
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [16:0]   prev_dl;
    initial begin
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_vld", DW'(out_if.tvalid), DW'(1'b1));
                    chk("hold_data", out_if.tdata, prev_data);
                    chk("hold_dest_last", DW'({out_if.tdest, out_if.tlast}), DW'(prev_dl));
                end
                if (out_if.tvalid && out_if.tready) begin
                    if (exp_out.size() == 0) begin
                        n_chk++;
                        $display("FAIL out_unexpected: got beat %0h expected none", out_if.tdata);
                    end else begin
                        ob_t e;
                        e = exp_out.pop_front();
                        chk("out_data", out_if.tdata, e.data);
                        chk("out_dest", DW'(out_if.tdest), DW'(e.dest));
                        chk("out_last", DW'(out_if.tlast), DW'(e.last));
                    end
                end
                prev_stall = out_if.tvalid && !out_if.tready;
                prev_data  = out_if.tdata;
                prev_dl    = {out_if.tdest, out_if.tlast};
                if (stat_vld && stat_rdy) begin
                    if (exp_st.size() == 0) begin
                        n_chk++;
                        $display("FAIL stat_unexpected: got qid %0h expected none", stat_qid);
                    end else begin
                        st_t s;
                        s = exp_st.pop_front();
                        chk("stat_qid", DW'(stat_qid), DW'(s.qid));
                        chk("stat_tmh", DW'(stat_tmh), DW'(s.tmh));
                        chk("stat_beats", DW'(stat_beats), DW'(s.beats));
                        chk("stat_err", DW'(stat_err), DW'(s.err));
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [DESTW-1:0] dest,
                             input logic user, input logic last);
        bit done;
        done = 0;
        @(negedge clk);
        in_if.tdata  = d;
        in_if.tdest  = dest;
        in_if.tuser  = user;
        in_if.tlast  = last;
        in_if.tvalid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (in_if.tready) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            n_chk++;
            $display("FAIL send_timeout: got no tready expected accept");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_if.tvalid = 1'b0;
        in_if.tuser  = 1'b0;
        in_if.tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [QW-1:0] qid, input logic [DESTW-1:0] dest,
                            input logic [TW-1:0] tmh, input int n, input int base,
                            input logic [3:0] eerr, input logic [DESTW-1:0] edest);
        for (int i = 0; i < n; i++) exp_out.push_back('{pld(base + i), edest, (i == n - 1)});
        exp_st.push_back('{qid, tmh, CW'(n), eerr});
        send_beat(hdr(qid, tmh), dest, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) send_beat(pld(base + i), dest, 1'b0, (i == n - 1));
        idle();
    endtask

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 300 && (exp_out.size() != 0 || exp_st.size() != 0); k++)
            @(negedge clk);
        n_chk++;
        if (exp_out.size() == 0 && exp_st.size() == 0) n_pass++;
        else $display("FAIL %s_drain: got %0d beats %0d stats pending expected 0 0",
                      nm, exp_out.size(), exp_st.size());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit acc;
        rst          = 1'b1;
        stat_rdy     = 1'b1;
        in_if.tdata  = '0;
        in_if.tdest  = '0;
        in_if.tuser  = 1'b0;
        in_if.tlast  = 1'b0;
        in_if.tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_vld", DW'(out_if.tvalid), '0);
        chk("rst_out_data", out_if.tdata, '0);
        chk("rst_out_dest_last", DW'({out_if.tdest, out_if.tlast}), '0);
        chk("rst_stat_vld", DW'(stat_vld), '0);
        chk("rst_stat_rec", DW'({stat_qid, stat_tmh, stat_beats, stat_err}), '0);
        rst = 1'b0;

        // basic packet
        send_pkt(11'h2A, 16'h2A, 32'hDEAD_BEEF, 3, 1, 4'b0000, 16'h2A);
        wait_drain("basic");

        // same packet with output backpressure toggling
        tog_en = 1'b1;
        send_pkt(11'h2A, 16'h2A, 32'hDEAD_BEEF, 3, 10, 4'b0000, 16'h2A);
        wait_drain("toggle");
        tog_en = 1'b0;

        // payload without header
        exp_st.push_back('{11'h0, 32'h0, 16'd0, 4'b0001});
        send_beat(pld(20), 16'h2A, 1'b0, 1'b0);
        send_beat(pld(21), 16'h2A, 1'b0, 1'b1);
        idle();
        wait_drain("no_hdr");

        // header with tlast -> empty packet
        exp_st.push_back('{11'h11, 32'h1234_5678, 16'd0, 4'b1000});
        send_beat(hdr(11'h11, 32'h1234_5678), 16'h11, 1'b1, 1'b1);
        idle();
        // tdest mismatch: tdest 0x05, qid 0x06
        send_pkt(11'h06, 16'h05, 32'hCAFE_0006, 1, 30, 4'b0010, 16'h06);
        wait_drain("empty_mis");

        // status FIFO backpressure
        stat_rdy = 1'b0;
        for (int p = 0; p < 4; p++)
            send_pkt(QW'(11'h20 + p), DESTW'(16'h20 + p), 32'h1000 + 32'(p), 1, 40 + p, 4'b0000,
                     DESTW'(16'h20 + p));
        repeat (3) @(negedge clk);
        #1;
        chk("fifo_vld_held", DW'(stat_vld), DW'(1'b1));
        exp_out.push_back('{pld(44), 16'h24, 1'b1});
        exp_st.push_back('{11'h24, 32'h1004, 16'd1, 4'b0000});
        send_beat(hdr(11'h24, 32'h1004), 16'h24, 1'b1, 1'b0);
        @(negedge clk);
        in_if.tdata = pld(44);
        in_if.tdest = 16'h24;
        in_if.tuser = 1'b0;
        in_if.tlast = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("full_tready", DW'(in_if.tready), '0);
            @(negedge clk);
        end
        stat_rdy = 1'b1;
        #1;
        chk("full_tready_pulse", DW'(in_if.tready), '0);
        @(negedge clk);
        stat_rdy = 1'b0;
        acc = 0;
        for (int k = 0; k < 10 && !acc; k++) begin
            #1;
            if (in_if.tready) begin
                @(posedge clk);
                acc = 1;
            end else begin
                @(negedge clk);
            end
        end
        chk("full_accept_after_pop", DW'(acc), DW'(1'b1));
        idle();
        stat_rdy = 1'b1;
        wait_drain("fifo_full");

        // reset during the second payload beat
        exp_out.push_back('{pld(50), 16'h10, 1'b0});
        send_beat(hdr(11'h10, 32'h0000_0010), 16'h10, 1'b1, 1'b0);
        send_beat(pld(50), 16'h10, 1'b0, 1'b0);
        @(negedge clk);
        in_if.tdata = pld(51);
        in_if.tlast = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_vld", DW'(out_if.tvalid), '0);
        chk("mid_rst_stat_vld", DW'(stat_vld), '0);
        @(negedge clk);
        in_if.tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send_pkt(11'h01, 16'h01, 32'h0000_0001, 1, 60, 4'b0000, 16'h01);
        wait_drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
